textmode_console: RTL and testbench

//   Terminal-style writer for the 30x80 text display. Consumes a byte stream
//   (valid/ready) and drives the display-memory access port (dsp_*) directly

---
 rtl/textmode_console_if.sv | 30 +++
 rtl/textmode_console.sv | 257 +++++++++++++++++++++++++
 tb/tb_textmode_console.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/textmode_console_if.sv
// textmode_console_if
//   Bundles the byte-stream handshake and the display-memory access port of
//   textmode_console.
//   Stream : in_valid, in_ready, in_data[7:0], in_att[7:0]
//   Display: dsp_row[4:0], dsp_col[6:0], dsp_en, dsp_wr, dsp_wr_data[15:0],
//            dsp_rd_data[15:0] (returned the cycle after a read strobe)
//   slave  : the console side (accepts bytes, drives the display port)
//   master : the byte source plus display memory side
interface textmode_console_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  in_att;
    logic [4:0]  dsp_row;
    logic [6:0]  dsp_col;
    logic        dsp_en;
    logic        dsp_wr;
    logic [15:0] dsp_wr_data;
    logic [15:0] dsp_rd_data;

    modport slave (
        input  in_valid, in_data, in_att, dsp_rd_data,
        output in_ready, dsp_row, dsp_col, dsp_en, dsp_wr, dsp_wr_data
    );

    modport master (
        output in_valid, in_data, in_att, dsp_rd_data,
        input  in_ready, dsp_row, dsp_col, dsp_en, dsp_wr, dsp_wr_data
    );
endinterface

// File: rtl/textmode_console.sv
// textmode_console
//   Terminal-style writer for a ROWS x COLS text display. Takes a byte stream,
//   keeps the cursor, interprets CR/BS/TAB/LF/FF, wraps lines, scrolls by
//   copying every row up one line and blanking the last, and clears the screen.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     bus (slave)     byte stream in / display-memory access port out
//     busy            high whenever the block is not idle
//     cur_row/cur_col cursor position
//   Timing: every display access is visible in the same cycle as the state
//   that issues it (it is registered on the edge that enters that state).
//   The one exception is the first CLR_ALL cycle after reset, which is a dead
//   cycle because reset forces all display outputs low.
module textmode_console #(
    parameter int          ROWS     = 30,
    parameter int          COLS     = 80,
    parameter logic [7:0]  DEF_ATTR = 8'h07
) (
    input  logic               clk,
    input  logic               rst_n,
    textmode_console_if.slave  bus,
    output logic               busy,
    output logic [4:0]         cur_row,
    output logic [6:0]         cur_col
);
    typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR_LINE, CLR_ALL} state_t;

    localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);
    localparam logic [4:0]  COPY_LAST_ROW = 5'(ROWS - 2);
    localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
    localparam logic [7:0]  COLS_W        = 8'(COLS);
    localparam logic [15:0] BLANK         = {DEF_ATTR, 8'h20};

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  scan_row_q, scan_row_d;   // cell addressed by the access now on the port
    logic [6:0]  scan_col_q, scan_col_d;
    logic        dsp_en_q, dsp_en_d;
    logic        dsp_wr_q, dsp_wr_d;
    logic [4:0]  dsp_row_q, dsp_row_d;
    logic [6:0]  dsp_col_q, dsp_col_d;
    logic [15:0] dsp_wr_data_q, dsp_wr_data_d;

    logic        accept_s;
    logic        printable_s;
    logic [7:0]  tab_col_s;
    logic        go_scr_s;

    assign accept_s    = bus.in_valid && (state_q == IDLE);
    assign printable_s = (bus.in_data >= 8'h20) && (bus.in_data != 8'h7F);
    assign tab_col_s   = {1'b0, col_q[6:3], 3'b000} + 8'd8;

    assign bus.in_ready = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign cur_row      = row_q;
    assign cur_col      = col_q;
    assign bus.dsp_en   = dsp_en_q;
    assign bus.dsp_wr   = dsp_wr_q;
    assign bus.dsp_row  = dsp_row_q;
    assign bus.dsp_col  = dsp_col_q;
    // The copy write happens in the cycle the read data returns, so the
    // returned word is steered straight onto the write-data lines then.
    assign bus.dsp_wr_data = (state_q == SCR_WR) ? bus.dsp_rd_data : dsp_wr_data_q;

    // Next-state, cursor, scan counter and next display access.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        scan_row_d    = scan_row_q;
        scan_col_d    = scan_col_q;
        dsp_en_d      = 1'b0;
        dsp_wr_d      = 1'b0;
        dsp_row_d     = 5'd0;
        dsp_col_d     = 7'd0;
        dsp_wr_data_d = 16'h0000;
        go_scr_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s && printable_s) begin
                    state_d       = PUT;
                    dsp_en_d      = 1'b1;
                    dsp_wr_d      = 1'b1;
                    dsp_row_d     = row_q;
                    dsp_col_d     = col_q;
                    dsp_wr_data_d = {bus.in_att, bus.in_data};
                end else if (accept_s) begin
                    case (bus.in_data)
                        8'h0D: col_d = 7'd0;
                        8'h08: col_d = (col_q == 7'd0) ? 7'd0 : col_q - 7'd1;
                        8'h09: begin
                            if (tab_col_s >= COLS_W) begin
                                col_d = 7'd0;
                                if (row_q == LAST_ROW) begin
                                    go_scr_s = 1'b1;
                                end else begin
                                    row_d = row_q + 5'd1;
                                end
                            end else begin
                                col_d = tab_col_s[6:0];
                            end
                        end
                        8'h0A: begin
                            if (row_q == LAST_ROW) begin
                                go_scr_s = 1'b1;
                            end else begin
                                row_d = row_q + 5'd1;
                            end
                        end
                        8'h0C: begin
                            state_d       = CLR_ALL;
                            row_d         = 5'd0;
                            col_d         = 7'd0;
                            scan_row_d    = 5'd0;
                            scan_col_d    = 7'd0;
                            dsp_en_d      = 1'b1;
                            dsp_wr_d      = 1'b1;
                            dsp_wr_data_d = BLANK;
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            PUT: begin
                if (col_q == LAST_COL) begin
                    col_d = 7'd0;
                    if (row_q == LAST_ROW) begin
                        go_scr_s = 1'b1;
                    end else begin
                        row_d   = row_q + 5'd1;
                        state_d = IDLE;
                    end
                end else begin
                    col_d   = col_q + 7'd1;
                    state_d = IDLE;
                end
            end
            SCR_RD: begin
                state_d   = SCR_WR;
                dsp_en_d  = 1'b1;
                dsp_wr_d  = 1'b1;
                dsp_row_d = scan_row_q;
                dsp_col_d = scan_col_q;
            end
            SCR_WR: begin
                if (scan_col_q == LAST_COL) begin
                    if (scan_row_q == COPY_LAST_ROW) begin
                        state_d       = CLR_LINE;
                        scan_row_d    = LAST_ROW;
                        scan_col_d    = 7'd0;
                        dsp_en_d      = 1'b1;
                        dsp_wr_d      = 1'b1;
                        dsp_row_d     = LAST_ROW;
                        dsp_wr_data_d = BLANK;
                    end else begin
                        state_d    = SCR_RD;
                        scan_row_d = scan_row_q + 5'd1;
                        scan_col_d = 7'd0;
                        dsp_en_d   = 1'b1;
                        dsp_row_d  = scan_row_q + 5'd2;
                    end
                end else begin
                    state_d    = SCR_RD;
                    scan_col_d = scan_col_q + 7'd1;
                    dsp_en_d   = 1'b1;
                    dsp_row_d  = scan_row_q + 5'd1;
                    dsp_col_d  = scan_col_q + 7'd1;
                end
            end
            CLR_LINE: begin
                if (scan_col_q == LAST_COL) begin
                    state_d = IDLE;
                end else begin
                    scan_col_d    = scan_col_q + 7'd1;
                    dsp_en_d      = 1'b1;
                    dsp_wr_d      = 1'b1;
                    dsp_row_d     = LAST_ROW;
                    dsp_col_d     = scan_col_q + 7'd1;
                    dsp_wr_data_d = BLANK;
                end
            end
            CLR_ALL: begin
                if (!dsp_en_q) begin
                    // dead cycle straight after reset: issue the first cell now
                    scan_row_d    = 5'd0;
                    scan_col_d    = 7'd0;
                    dsp_en_d      = 1'b1;
                    dsp_wr_d      = 1'b1;
                    dsp_wr_data_d = BLANK;
                end else if (scan_col_q == LAST_COL) begin
                    if (scan_row_q == LAST_ROW) begin
                        state_d = IDLE;
                    end else begin
                        scan_row_d    = scan_row_q + 5'd1;
                        scan_col_d    = 7'd0;
                        dsp_en_d      = 1'b1;
                        dsp_wr_d      = 1'b1;
                        dsp_row_d     = scan_row_q + 5'd1;
                        dsp_wr_data_d = BLANK;
                    end
                end else begin
                    scan_col_d    = scan_col_q + 7'd1;
                    dsp_en_d      = 1'b1;
                    dsp_wr_d      = 1'b1;
                    dsp_row_d     = scan_row_q;
                    dsp_col_d     = scan_col_q + 7'd1;
                    dsp_wr_data_d = BLANK;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every scroll starts by reading the first cell of row 1.
        if (go_scr_s) begin
            state_d    = SCR_RD;
            scan_row_d = 5'd0;
            scan_col_d = 7'd0;
            dsp_en_d   = 1'b1;
            dsp_wr_d   = 1'b0;
            dsp_row_d  = 5'd1;
            dsp_col_d  = 7'd0;
        end else begin
            go_scr_s = 1'b0;
        end
    end

    // State, cursor, scan counters and registered display port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CLR_ALL;
            row_q         <= 5'd0;
            col_q         <= 7'd0;
            scan_row_q    <= 5'd0;
            scan_col_q    <= 7'd0;
            dsp_en_q      <= 1'b0;
            dsp_wr_q      <= 1'b0;
            dsp_row_q     <= 5'd0;
            dsp_col_q     <= 7'd0;
            dsp_wr_data_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            scan_row_q    <= scan_row_d;
            scan_col_q    <= scan_col_d;
            dsp_en_q      <= dsp_en_d;
            dsp_wr_q      <= dsp_wr_d;
            dsp_row_q     <= dsp_row_d;
            dsp_col_q     <= dsp_col_d;
            dsp_wr_data_q <= dsp_wr_data_d;
        end
    end
endmodule

// File: tb/tb_textmode_console.sv
// tb_textmode_console
//   Directed bench for textmode_console: a table of single-byte vectors with
//   hand-computed writes and cursor positions, plus hand-written sequences for
//   clear, scroll, back-pressure during scroll, reset abort and form feed.
//   A 30x80 display memory model answers reads one cycle after the strobe.
module tb_textmode_console;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       busy;
    logic [4:0] cur_row;
    logic [6:0] cur_col;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    textmode_console_if bus();

    textmode_console dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .cur_row (cur_row),
        .cur_col (cur_col)
    );

    // display memory model
    logic [15:0] mem [0:29][0:79];
    logic [15:0] rd_q;
    int          addr_err = 0;
    int          byte_hits [0:255];
    logic        preload_req = 1'b0;

    function automatic logic [15:0] pat(input int r, input int c);
        return {3'b000, 5'(r), 1'b0, 7'(c)};
    endfunction

    assign bus.dsp_rd_data = rd_q;

    // Memory model: preload pattern, writes, one-cycle-late reads.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int r = 0; r < 30; r++)
                for (int c = 0; c < 80; c++)
                    mem[r][c] <= pat(r, c);
            for (int i = 0; i < 256; i++) byte_hits[i] <= 0;
        end else if (bus.dsp_en) begin
            if (bus.dsp_row > 5'd29 || bus.dsp_col > 7'd79) begin
                addr_err <= addr_err + 1;
            end else if (bus.dsp_wr) begin
                mem[bus.dsp_row][bus.dsp_col] <= bus.dsp_wr_data;
                if (bus.dsp_wr_data[15:8] == 8'hA5)
                    byte_hits[bus.dsp_wr_data[7:0]] <= byte_hits[bus.dsp_wr_data[7:0]] + 1;
            end else begin
                rd_q <= mem[bus.dsp_row][bus.dsp_col];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (!bus.in_ready && n < max) begin
            step();
            n++;
        end
    endtask

    // Present one byte when ready; returns one cycle after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [7:0] a);
        int n;
        wait_ready(6000, n);
        check("send_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_att   = a;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check(name, {20'd0, cur_row, cur_col}, {20'd0, 5'(r), 7'(c)});
    endtask

    // Follow a full-screen clear from now until in_ready.
    task automatic run_clear(input string name);
        int nw = 0, bad = 0, last = -2, cyc = 0, cells = 0;
        while (!bus.in_ready && cyc < 3000) begin
            if (bus.dsp_en) begin
                if (!bus.dsp_wr || bus.dsp_row != 5'(nw / 80) || bus.dsp_col != 7'(nw % 80) ||
                    bus.dsp_wr_data != 16'h0720)
                    bad++;
                nw++;
                last = cyc;
            end
            step();
            cyc++;
        end
        check({name, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({name, "_writes"}, nw, 2400);
        check({name, "_order"}, bad, 0);
        check({name, "_ready_lat"}, cyc, last + 1);
        check_cursor({name, "_cursor"}, 0, 0);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                if (mem[r][c] !== 16'h0720) cells++;
        check({name, "_mem"}, cells, 0);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [7:0]  a;
        logic        wr;
        logic [4:0]  wrow;
        logic [6:0]  wcol;
        logic [15:0] wdata;
        logic [4:0]  crow;
        logic [6:0]  ccol;
    } vec_t;

    vec_t vt[$];

    initial begin
        int n, bad, idx, first_acc, cyc;
        logic rdy;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_att   = 8'h00;

        // --- reset and power-up clear ---
        #2 rst_n = 1'b0;
        #1;
        check("rst_dsp", {bus.dsp_en, bus.dsp_wr, bus.dsp_row, bus.dsp_col, bus.dsp_wr_data}, 32'd0);
        check("rst_ready_busy", {30'd0, bus.in_ready, busy}, 32'd1);
        check_cursor("rst_cursor", 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_clear("reset_clear");

        // --- table-driven single bytes ---
        vt.push_back(vec_t'{8'h41, 8'h1E, 1'b1, 5'd0, 7'd0,  16'h1E41, 5'd0, 7'd1});
        vt.push_back(vec_t'{8'h0A, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd1, 7'd1});
        vt.push_back(vec_t'{8'h0A, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd2, 7'd1});
        vt.push_back(vec_t'{8'h0A, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd3, 7'd1});
        vt.push_back(vec_t'{8'h0D, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd3, 7'd0});
        vt.push_back(vec_t'{8'h09, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd3, 7'd8});
        vt.push_back(vec_t'{8'h61, 8'h07, 1'b1, 5'd3, 7'd8,  16'h0761, 5'd3, 7'd9});
        vt.push_back(vec_t'{8'h62, 8'h2C, 1'b1, 5'd3, 7'd9,  16'h2C62, 5'd3, 7'd10});
        vt.push_back(vec_t'{8'h08, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd3, 7'd9});
        vt.push_back(vec_t'{8'h09, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd3, 7'd16});
        vt.push_back(vec_t'{8'h0D, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd3, 7'd0});
        vt.push_back(vec_t'{8'h08, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd3, 7'd0});
        vt.push_back(vec_t'{8'h0A, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd4, 7'd0});
        vt.push_back(vec_t'{8'h00, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd4, 7'd0});
        vt.push_back(vec_t'{8'h7F, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd4, 7'd0});
        vt.push_back(vec_t'{8'h80, 8'h42, 1'b1, 5'd4, 7'd0,  16'h4280, 5'd4, 7'd1});
        vt.push_back(vec_t'{8'h1B, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd4, 7'd1});
        vt.push_back(vec_t'{8'h7E, 8'h13, 1'b1, 5'd4, 7'd1,  16'h137E, 5'd4, 7'd2});
        for (int k = 1; k <= 9; k++)
            vt.push_back(vec_t'{8'h09, 8'h00, 1'b0, 5'd0, 7'd0, 16'h0000, 5'd4, 7'(8 * k)});
        vt.push_back(vec_t'{8'h09, 8'h00, 1'b0, 5'd0, 7'd0,  16'h0000, 5'd5, 7'd0});

        foreach (vt[i]) begin
            send(vt[i].d, vt[i].a);
            if (vt[i].wr)
                check($sformatf("vec%0d_write", i),
                      {2'b00, bus.dsp_en, bus.dsp_wr, bus.dsp_row, bus.dsp_col, bus.dsp_wr_data},
                      {2'b00, 1'b1, 1'b1, vt[i].wrow, vt[i].wcol, vt[i].wdata});
            else
                check($sformatf("vec%0d_noaccess", i), {31'd0, bus.dsp_en}, 32'd0);
            wait_ready(4, n);
            check_cursor($sformatf("vec%0d_cursor", i), vt[i].crow, vt[i].ccol);
        end

        // --- walk to row 28, wrap a printable onto row 29, then reach (29,79) ---
        repeat (23) send(8'h0A, 8'h00);
        repeat (9) send(8'h09, 8'h00);
        repeat (8) send(8'h78, 8'h07);
        wait_ready(4, n);
        check_cursor("wrap_to_last_row", 29, 0);
        repeat (9) send(8'h09, 8'h00);
        repeat (7) send(8'h78, 8'h07);
        wait_ready(4, n);
        check_cursor("at_29_79", 29, 79);

        // --- printable at the last cell triggers a scroll ---
        preload_req = 1'b1;
        step();
        preload_req = 1'b0;
        send(8'h5A, 8'h1E);
        check("scroll_put",
              {2'b00, bus.dsp_en, bus.dsp_wr, bus.dsp_row, bus.dsp_col, bus.dsp_wr_data},
              {2'b00, 1'b1, 1'b1, 5'd29, 7'd79, 16'h1E5A});
        wait_ready(6000, n);
        check("scroll_latency", n, 4721);
        bad = 0;
        for (int r = 0; r < 29; r++)
            for (int c = 0; c < 80; c++)
                if (mem[r][c] !== ((r == 28 && c == 79) ? 16'h1E5A : pat(r + 1, c))) bad++;
        for (int c = 0; c < 80; c++)
            if (mem[29][c] !== 16'h0720) bad++;
        check("scroll_mem", bad, 0);
        check_cursor("scroll_cursor", 29, 0);

        // --- LF on the last row scrolls while a byte stream is held pending ---
        send(8'h0A, 8'h00);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h41;
        bus.in_att   = 8'hA5;
        idx = 0;
        first_acc = -1;
        cyc = 0;
        while (idx < 10 && cyc < 6000) begin
            rdy = bus.in_ready;
            step();
            cyc++;
            if (rdy) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
                bus.in_data = 8'h41 + 8'(idx);
                if (idx == 10) bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        wait_ready(10, n);
        check("stream_count", idx, 10);
        check("stream_first_accept", first_acc, 4721);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (byte_hits[8'h41 + k] != 1) bad++;
            if (mem[29][k] !== {8'hA5, 8'(8'h41 + k)}) bad++;
        end
        check("stream_once_each", bad, 0);
        check_cursor("stream_cursor", 29, 10);

        // --- reset in the middle of a scroll ---
        send(8'h0A, 8'h00);
        repeat (100) step();
        #2 rst_n = 1'b0;
        #1;
        check("abort_dsp_en", {31'd0, bus.dsp_en}, 32'd0);
        check("abort_busy", {30'd0, bus.in_ready, busy}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_clear("abort_restart");

        // --- form feed from (12,40) ---
        repeat (12) send(8'h0A, 8'h00);
        repeat (5) send(8'h09, 8'h00);
        wait_ready(4, n);
        check_cursor("pos_12_40", 12, 40);
        send(8'h0C, 8'h00);
        run_clear("ff_clear");

        check("addr_range", addr_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
